// File: rtl/neander_stack_ctrl_if.sv
// Interface bundle for neander_stack_ctrl: operation handshake, SP load,
// memory bus and status flags. "master" is the controller side, "slave" is
// the side that issues operations and serves the memory bus.
interface neander_stack_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              op_valid;
    logic              op_ready;
    logic [1:0]        op_kind;
    logic [DATA_W-1:0] wdata;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              sp_load;
    logic [ADDR_W-1:0] sp_load_val;
    logic [ADDR_W-1:0] sp;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              ovf;
    logic              unf;
    logic              flag_clr;

    modport master (
        input  op_valid, op_kind, wdata, sp_load, sp_load_val,
               mem_ack, mem_rdata, flag_clr,
        output op_ready, done, rdata, sp, mem_req, mem_we, mem_addr,
               mem_wdata, ovf, unf
    );

    modport slave (
        output op_valid, op_kind, wdata, sp_load, sp_load_val,
               mem_ack, mem_rdata, flag_clr,
        input  op_ready, done, rdata, sp, mem_req, mem_we, mem_addr,
               mem_wdata, ovf, unf
    );
endinterface

// File: rtl/neander_stack_ctrl.sv
// Stack controller: PUSH/POP/PEEK over a request/ack memory bus with a
// downward-growing stack (SP points at the top entry; STACK_TOP means empty).
// Optional macro NEANDER_STACK_GUARD_EN enables overflow/underflow guards
// with sticky ovf/unf flags; without it the flags read 0 and SP wraps.
module neander_stack_ctrl #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] STACK_TOP   = '1,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = ADDR_W'(8'hC0)
) (
    input logic                   clk,
    input logic                   reset,
    neander_stack_ctrl_if.master  bus
);

    typedef enum logic [1:0] {IDLE, WR, RD, FIN} state_e;
    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_PEEK = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    state_e            state;
    state_e            next_state;
    op_e               cur_op;
    op_e               op_latched;
    logic [ADDR_W-1:0] sp;
    logic [DATA_W-1:0] rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              done;
    logic              ovf;
    logic              unf;
    logic              op_ready;
    logic              accept;
    logic              ack_hit;
    logic              ovf_event;
    logic              unf_event;
    logic              guard_hit;

    assign op_ready  = (state == IDLE) && !bus.sp_load;
    assign cur_op    = op_e'(bus.op_kind);
    assign accept    = bus.op_valid && op_ready;
    assign ack_hit   = ((state == WR) || (state == RD)) && bus.mem_ack;
    assign guard_hit = ovf_event || unf_event;

`ifdef NEANDER_STACK_GUARD_EN
    assign ovf_event = accept && (cur_op == OP_PUSH) && (sp == STACK_LIMIT);
    assign unf_event = accept && ((cur_op == OP_POP) || (cur_op == OP_PEEK))
                       && (sp == STACK_TOP);

    // Sticky guard flags; a new event in the same cycle beats flag_clr
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (bus.flag_clr) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end
            if (ovf_event) ovf <= 1'b1;
            if (unf_event) unf <= 1'b1;
        end
    end
`else
    logic unused_guard;
    assign unused_guard = ^{bus.flag_clr, STACK_LIMIT};
    assign ovf_event    = 1'b0;
    assign unf_event    = 1'b0;
    assign ovf          = 1'b0;
    assign unf          = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic: guarded and reserved ops skip memory and go to FIN
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (guard_hit) begin
                        next_state = FIN;
                    end else begin
                        case (cur_op)
                            OP_PUSH:         next_state = WR;
                            OP_POP, OP_PEEK: next_state = RD;
                            default:         next_state = FIN;
                        endcase
                    end
                end
            end
            WR, RD:  if (bus.mem_ack) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: bus launch on acceptance, SP/rdata update on ack, done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            sp         <= STACK_TOP;
            rdata      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            done       <= 1'b0;
            op_latched <= OP_PUSH;
        end else begin
            done <= (next_state == FIN);
            if ((state == IDLE) && bus.sp_load) sp <= bus.sp_load_val;
            if (accept) begin
                op_latched <= cur_op;
                if (!guard_hit) begin
                    case (cur_op)
                        OP_PUSH: begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= sp - 1'b1;
                            mem_wdata <= bus.wdata;
                        end
                        OP_POP, OP_PEEK: begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= sp;
                        end
                        default: ;
                    endcase
                end
            end
            if (ack_hit) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                case (op_latched)
                    OP_PUSH: sp <= sp - 1'b1;
                    OP_POP: begin
                        sp    <= sp + 1'b1;
                        rdata <= bus.mem_rdata;
                    end
                    OP_PEEK: rdata <= bus.mem_rdata;
                    default: ;
                endcase
            end
        end
    end

    assign bus.op_ready  = op_ready;
    assign bus.done      = done;
    assign bus.rdata     = rdata;
    assign bus.sp        = sp;
    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.ovf       = ovf;
    assign bus.unf       = unf;

endmodule

// File: tb/tb_neander_stack_ctrl.sv
// Scoreboard bench for neander_stack_ctrl: directed scenarios plus random
// operations, checked against a plain stack model (array + SP arithmetic).
module tb_neander_stack_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 8;
    localparam logic [7:0]  TOP   = 8'hFF;
    localparam logic [7:0]  LIMIT = 8'hC0;
`ifdef NEANDER_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    neander_stack_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    neander_stack_ctrl #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .STACK_TOP(TOP),
        .STACK_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master)
    );

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } acc_t;

    typedef struct {
        logic [7:0] rdata;
        logic [7:0] sp;
        logic       ovf;
        logic       unf;
        int         cyc;
    } done_t;

    acc_t       acc_q[$];
    done_t      done_q[$];
    logic [7:0] model_mem[256];
    logic [7:0] mem_dev[256];
    logic [7:0] model_sp;
    logic [7:0] model_rdata;
    logic       model_ovf;
    logic       model_unf;

    int n_checks   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int cur_delay  = 0;
    int resp_mode  = 0;   // 0 normal, 1 never ack, 2 ack stuck high
    int wait_cnt   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder: acks after cur_delay wait cycles, serves mem_dev
    always @(negedge clk) begin
        if (reset) begin
            bus.mem_ack = 1'b0;
            wait_cnt    = 0;
        end else if (resp_mode == 1) begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 8'($urandom);
        end else if (resp_mode == 2) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 8'($urandom);
        end else if (bus.mem_ack) begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 8'($urandom);
        end else if (bus.mem_req) begin
            if (wait_cnt >= cur_delay) begin
                bus.mem_ack = 1'b1;
                wait_cnt    = 0;
                if (bus.mem_we) mem_dev[bus.mem_addr] = bus.mem_wdata;
                else            bus.mem_rdata = mem_dev[bus.mem_addr];
            end else begin
                wait_cnt++;
                bus.mem_rdata = 8'($urandom);
            end
        end
    end

    // Monitor: checks each new access, bus stability while waiting, and done
    acc_t held;
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_req = 1'b0;
        end else begin
            if (bus.mem_req) begin
                if (!prev_req) begin
                    if (acc_q.size() == 0) begin
                        chk("spurious_mem_req", bus.mem_req, 1'b0);
                        held = '{we: bus.mem_we, addr: bus.mem_addr, wdata: bus.mem_wdata};
                    end else begin
                        held = acc_q.pop_front();
                        chk("mem_we", bus.mem_we, held.we);
                        chk("mem_addr", bus.mem_addr, held.addr);
                        if (held.we) chk("mem_wdata", bus.mem_wdata, held.wdata);
                        else         held.wdata = bus.mem_wdata;
                    end
                end else begin
                    chk("hold_mem_we", bus.mem_we, held.we);
                    chk("hold_mem_addr", bus.mem_addr, held.addr);
                    chk("hold_mem_wdata", bus.mem_wdata, held.wdata);
                end
            end
            prev_req = bus.mem_req;
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    chk("spurious_done", bus.done, 1'b0);
                end else begin
                    done_t e;
                    e = done_q.pop_front();
                    chk("done_rdata", bus.rdata, e.rdata);
                    chk("done_sp", bus.sp, e.sp);
                    chk("done_ovf", bus.ovf, e.ovf);
                    chk("done_unf", bus.unf, e.unf);
                    chk("done_latency_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Reference model: the effect of an accepted operation on the stack
    task automatic model_accept(input logic [1:0] kind, input logic [7:0] wd, input int dly);
        bit    access;
        done_t e;
        access = 1'b0;
        case (kind)
            2'b00: begin
                if (GUARD && model_sp == LIMIT) begin
                    model_ovf = 1'b1;
                end else begin
                    model_sp = model_sp - 8'd1;
                    model_mem[model_sp] = wd;
                    acc_q.push_back('{we: 1'b1, addr: model_sp, wdata: wd});
                    access = 1'b1;
                end
            end
            2'b01, 2'b10: begin
                if (GUARD && model_sp == TOP) begin
                    model_unf = 1'b1;
                end else begin
                    acc_q.push_back('{we: 1'b0, addr: model_sp, wdata: 8'h00});
                    model_rdata = model_mem[model_sp];
                    if (kind == 2'b01) model_sp = model_sp + 8'd1;
                    access = 1'b1;
                end
            end
            default: ;
        endcase
        e = '{rdata: model_rdata, sp: model_sp, ovf: model_ovf, unf: model_unf,
              cyc: access ? cyc + 1 + dly : cyc};
        done_q.push_back(e);
    endtask

    task automatic issue(input logic [1:0] kind, input logic [7:0] wd, input int dly,
                         input bit ld, input logic [7:0] ldv, input bit clr);
        @(negedge clk);
        bus.op_valid    = 1'b1;
        bus.op_kind     = kind;
        bus.wdata       = wd;
        bus.sp_load     = ld;
        bus.sp_load_val = ldv;
        bus.flag_clr    = clr;
        cur_delay       = dly;
        #1;
        chk("op_ready", bus.op_ready, !ld);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.sp_load  = 1'b0;
        bus.flag_clr = 1'b0;
        if (clr) begin
            model_ovf = 1'b0;
            model_unf = 1'b0;
        end
        if (ld) model_sp = ldv;
        else    model_accept(kind, wd, dly);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (done_q.size() != 0) begin
            chk("done_timeout_pending", done_q.size(), 0);
            done_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset         = 1'b1;
        bus.op_valid  = 1'b0;
        bus.sp_load   = 1'b0;
        bus.flag_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_sp    = TOP;
        model_rdata = 8'h00;
        model_ovf   = 1'b0;
        model_unf   = 1'b0;
        done_q.delete();
        acc_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] saved;
        logic [7:0] ldv;
        int         r;

        bus.op_valid    = 1'b0;
        bus.op_kind     = 2'b00;
        bus.wdata       = 8'h00;
        bus.sp_load     = 1'b0;
        bus.sp_load_val = 8'h00;
        bus.flag_clr    = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem_dev[i]   = 8'($urandom);
            model_mem[i] = mem_dev[i];
        end

        // Reset values
        reset_dut();
        @(negedge clk);
        chk("rst_sp", bus.sp, TOP);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_ovf", bus.ovf, 1'b0);
        chk("rst_unf", bus.unf, 1'b0);
        chk("rst_rdata", bus.rdata, 8'h00);
        chk("rst_mem_addr", bus.mem_addr, 8'h00);
        chk("rst_mem_wdata", bus.mem_wdata, 8'h00);
        chk("rst_op_ready", bus.op_ready, 1'b1);

        // Single PUSH with immediate ack
        issue(2'b00, 8'h5A, 0, 1'b0, 8'h00, 1'b0);
        wait_done();
        chk("push_sp", bus.sp, 8'hFE);
        chk("push_mem_written", mem_dev[8'hFE], 8'h5A);

        // Two PUSHes then POP with a 2-cycle ack delay
        reset_dut();
        issue(2'b00, 8'h11, 0, 1'b0, 8'h00, 1'b0);
        wait_done();
        issue(2'b00, 8'h22, 0, 1'b0, 8'h00, 1'b0);
        wait_done();
        issue(2'b01, 8'h00, 2, 1'b0, 8'h00, 1'b0);
        wait_done();
        chk("pop_rdata", bus.rdata, 8'h22);
        chk("pop_sp", bus.sp, 8'hFE);

        // PEEK leaves SP alone
        reset_dut();
        issue(2'b00, 8'h33, 1, 1'b0, 8'h00, 1'b0);
        wait_done();
        issue(2'b10, 8'h00, 0, 1'b0, 8'h00, 1'b0);
        wait_done();
        chk("peek_rdata", bus.rdata, 8'h33);
        chk("peek_sp", bus.sp, 8'hFE);

        // Reserved op completes without a memory access
        issue(2'b11, 8'h00, 0, 1'b0, 8'h00, 1'b0);
        wait_done();
        chk("rsvd_sp", bus.sp, 8'hFE);

`ifdef NEANDER_STACK_GUARD_EN
        // Guards: POP on empty, PUSH at limit, flag clear, set-wins-over-clear
        reset_dut();
        issue(2'b01, 8'h00, 0, 1'b0, 8'h00, 1'b0);
        wait_done();
        chk("guard_unf", bus.unf, 1'b1);
        chk("guard_unf_sp", bus.sp, 8'hFF);
        issue(2'b00, 8'h00, 0, 1'b1, LIMIT, 1'b0);
        issue(2'b00, 8'h77, 0, 1'b0, 8'h00, 1'b0);
        wait_done();
        chk("guard_ovf", bus.ovf, 1'b1);
        chk("guard_ovf_sp", bus.sp, LIMIT);
        @(negedge clk);
        bus.flag_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.flag_clr = 1'b0;
        model_ovf = 1'b0;
        model_unf = 1'b0;
        @(negedge clk);
        chk("flag_clr_ovf", bus.ovf, 1'b0);
        chk("flag_clr_unf", bus.unf, 1'b0);
        issue(2'b00, 8'h78, 0, 1'b0, 8'h00, 1'b1);
        wait_done();
        chk("set_beats_clr_ovf", bus.ovf, 1'b1);
`else
        // No guard: POP on empty wraps SP to 0
        reset_dut();
        issue(2'b01, 8'h00, 0, 1'b0, 8'h00, 1'b0);
        wait_done();
        chk("wrap_sp", bus.sp, 8'h00);
        chk("wrap_unf", bus.unf, 1'b0);
`endif

        // sp_load wins over op_valid in IDLE
        issue(2'b01, 8'h00, 0, 1'b1, 8'h80, 1'b0);
        @(negedge clk);
        chk("sp_load_sp", bus.sp, 8'h80);
        chk("sp_load_no_req", bus.mem_req, 1'b0);

        // Reset in the middle of a write that never gets acked
        reset_dut();
        resp_mode = 1;
        saved = model_mem[8'hFE];
        issue(2'b00, 8'hA5, 0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("abort_req_pending", bus.mem_req, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_mem[8'hFE] = saved;
        model_sp    = TOP;
        model_rdata = 8'h00;
        model_ovf   = 1'b0;
        model_unf   = 1'b0;
        done_q.delete();
        acc_q.delete();
        @(negedge clk);
        chk("abort_mem_req", bus.mem_req, 1'b0);
        chk("abort_sp", bus.sp, TOP);
        chk("abort_done", bus.done, 1'b0);
        resp_mode = 2;
        repeat (3) begin
            @(negedge clk);
            chk("late_ack_done", bus.done, 1'b0);
            chk("late_ack_sp", bus.sp, TOP);
        end
        resp_mode = 0;
        repeat (2) @(negedge clk);

        // Random operations
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 3))
                0:       ldv = TOP;
                1:       ldv = LIMIT;
                2:       ldv = LIMIT + 8'd1;
                default: ldv = 8'($urandom);
            endcase
            issue(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 3),
                  r < 8, ldv, (r >= 8 && r < 12));
            wait_done();
            @(negedge clk);
            chk("idle_sp", bus.sp, model_sp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
